bram_preload_ctl: RTL and testbench

//   Upstream sequencer for the TDP18K_FIFO preload (PL_*) interface.
//   - Takes a command (RAM_ID, base word address, length) and a valid/ready data stream.
//   - Writes the words into the addressed BRAM, or reads them back and compares (verify mode).
//   - Drives PL_ENA/PL_WEN/PL_REN/PL_ADDR/PL_DATA_IN; consumes PL_DATA_OUT. PL_CLK is tied to CLK at top level.

---
 rtl/bram_preload_ctl_if.sv | 50 +++++
 rtl/bram_preload_ctl.sv | 160 ++++++++++++++++
 tb/tb_bram_preload_ctl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_preload_ctl_if.sv
// Purpose: bundles the command, data stream, preload (PL_*) and status signals of bram_preload_ctl.
// Latency: n/a (signal bundle only).
// Backpressure: CMD_READY/DIN_READY carry the controller's backpressure to the upstream source.
interface bram_preload_ctl_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 11,
    parameter int ID_WIDTH   = 16
);
    // command channel
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WRITE;
    logic                  CMD_BCAST;
    logic [ID_WIDTH-1:0]   CMD_RAM_ID;
    logic [ADDR_WIDTH-1:0] CMD_BASE;
    logic [ADDR_WIDTH:0]   CMD_LEN;
    // data stream
    logic                  DIN_VALID;
    logic                  DIN_READY;
    logic [DATA_WIDTH-1:0] DIN_DATA;
    // preload port towards the BRAM
    logic                  PL_INIT;
    logic                  PL_ENA;
    logic                  PL_WEN;
    logic                  PL_REN;
    logic [31:0]           PL_ADDR;
    logic [DATA_WIDTH-1:0] PL_DATA_IN;
    logic [DATA_WIDTH-1:0] PL_DATA_OUT;
    // status
    logic                  BUSY;
    logic                  DONE;
    logic                  MISMATCH;
    logic [ADDR_WIDTH-1:0] ERR_ADDR;

    // upstream source plus BRAM side
    modport master (
        output CMD_VALID, CMD_WRITE, CMD_BCAST, CMD_RAM_ID, CMD_BASE, CMD_LEN,
        output DIN_VALID, DIN_DATA, PL_DATA_OUT,
        input  CMD_READY, DIN_READY, PL_INIT, PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA_IN,
        input  BUSY, DONE, MISMATCH, ERR_ADDR
    );

    // the preload controller
    modport slave (
        input  CMD_VALID, CMD_WRITE, CMD_BCAST, CMD_RAM_ID, CMD_BASE, CMD_LEN,
        input  DIN_VALID, DIN_DATA, PL_DATA_OUT,
        output CMD_READY, DIN_READY, PL_INIT, PL_ENA, PL_WEN, PL_REN, PL_ADDR, PL_DATA_IN,
        output BUSY, DONE, MISMATCH, ERR_ADDR
    );
endinterface

// File: rtl/bram_preload_ctl.sv
// Purpose: sequences a load or verify command over the TDP18K_FIFO preload port from a data stream.
// Latency: word accepted in cycle N strobes in N+1, verify compare in N+2; DONE 2 (load) / 3 (verify) cycles after last accept.
// Backpressure: CMD_READY only in IDLE; DIN_READY while words remain in RUN, full 1 word/cycle otherwise.
module bram_preload_ctl #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 11,
    parameter int ID_WIDTH   = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    bram_preload_ctl_if.slave  bus
);
    localparam int PAD_WIDTH = 32 - ID_WIDTH - ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH:0]   rem;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   ram_id;
    logic                  bcast;
    logic                  wr_mode;

    // stage 1: the strobe cycle
    logic                  s1_wen, s1_ren;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [DATA_WIDTH-1:0] s1_data;

    // stage 2: the compare cycle (verify only)
    logic                  s2_vld;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [DATA_WIDTH-1:0] s2_exp;

    logic                  mismatch;
    logic [ADDR_WIDTH-1:0] err_addr;

    logic cmd_rdy, din_rdy, busy, done;
    logic cmd_acc, din_acc, last_word;

    assign cmd_acc   = cmd_rdy && bus.CMD_VALID;
    assign din_acc   = din_rdy && bus.DIN_VALID;
    assign last_word = (rem == (ADDR_WIDTH+1)'(1));

    // next-state and state-decoded handshake/status outputs
    always_comb begin
        state_nxt = state;
        cmd_rdy   = 1'b0;
        din_rdy   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_rdy = 1'b1;
                busy    = 1'b0;
                if (bus.CMD_VALID)
                    state_nxt = (bus.CMD_LEN == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                din_rdy = (rem != '0);
                if (bus.DIN_VALID && din_rdy && last_word)
                    state_nxt = S_DRAIN;
            end
            // a read still in stage 1 means its compare lands next cycle
            S_DRAIN: begin
                if (!s1_ren)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // command fields latched at accept; address and remaining count step per accepted word
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rem     <= '0;
            addr    <= '0;
            ram_id  <= '0;
            bcast   <= 1'b0;
            wr_mode <= 1'b0;
        end else if (cmd_acc) begin
            rem     <= bus.CMD_LEN;
            addr    <= bus.CMD_BASE;
            ram_id  <= bus.CMD_RAM_ID;
            bcast   <= bus.CMD_BCAST;
            wr_mode <= bus.CMD_WRITE;
        end else if (din_acc) begin
            rem     <= rem - (ADDR_WIDTH+1)'(1);
            addr    <= addr + ADDR_WIDTH'(1);
        end
    end

    // stage 1: turn each accepted word into one write or read strobe
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_wen  <= 1'b0;
            s1_ren  <= 1'b0;
            s1_addr <= '0;
            s1_data <= '0;
        end else begin
            s1_wen <= din_acc && wr_mode;
            s1_ren <= din_acc && !wr_mode;
            if (din_acc) begin
                s1_addr <= addr;
                s1_data <= bus.DIN_DATA;
            end
        end
    end

    // stage 2: hold the expected word until the BRAM read data returns
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s2_vld  <= 1'b0;
            s2_addr <= '0;
            s2_exp  <= '0;
        end else begin
            s2_vld <= s1_ren;
            if (s1_ren) begin
                s2_addr <= s1_addr;
                s2_exp  <= s1_data;
            end
        end
    end

    // sticky first-mismatch capture, cleared by the next command accept
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mismatch <= 1'b0;
            err_addr <= '0;
        end else if (cmd_acc) begin
            mismatch <= 1'b0;
            err_addr <= '0;
        end else if (s2_vld && !mismatch && (bus.PL_DATA_OUT != s2_exp)) begin
            mismatch <= 1'b1;
            err_addr <= s2_addr;
        end
    end

    assign bus.CMD_READY  = cmd_rdy;
    assign bus.DIN_READY  = din_rdy;
    assign bus.BUSY       = busy;
    assign bus.DONE       = done;
    assign bus.MISMATCH   = mismatch;
    assign bus.ERR_ADDR   = err_addr;
    assign bus.PL_ENA     = busy;
    assign bus.PL_INIT    = busy && bcast;
    assign bus.PL_WEN     = s1_wen;
    assign bus.PL_REN     = s1_ren;
    assign bus.PL_ADDR    = busy ? {ram_id, {PAD_WIDTH{1'b0}}, s1_addr} : 32'h0;
    assign bus.PL_DATA_IN = s1_wen ? s1_data : '0;
endmodule

// File: tb/tb_bram_preload_ctl.sv
// Purpose: randomized and directed bench for bram_preload_ctl against a word-level reference model.
// Latency: n/a (testbench).
// Backpressure: drives DIN_VALID gaps (none, alternating, random) to exercise stream stalls.
module tb_bram_preload_ctl;
    localparam int DW    = 18;
    localparam int AW    = 11;
    localparam int IW    = 16;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int          cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit          w;
    } strobe_t;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    bram_preload_ctl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus ();

    bram_preload_ctl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    bit            mon_en = 1'b0;
    bit            active = 1'b0;
    logic          cur_bc;
    logic [IW-1:0] cur_id;
    bit            corrupt = 1'b0;
    logic [AW-1:0] corrupt_addr;
    logic [DW-1:0] ram     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] rd_next = '0;
    logic [DW-1:0] wq[$];
    int            acc_cyc[$];
    strobe_t       strobes[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // BRAM model: read data appears the cycle after a read strobe
    always @(posedge CLK) begin
        #1;
        bus.PL_DATA_OUT = rd_next;
    end

    // observe the preload port: invariants, strobe log, BRAM array update
    always @(negedge CLK) begin
        if (mon_en && RST_N) begin
            if (active)
                check("run_inv",
                      {6'b0, bus.BUSY, bus.PL_ENA, bus.PL_INIT, bus.PL_ADDR[31:11],
                       bus.PL_WEN & bus.PL_REN, (!bus.PL_WEN && bus.PL_DATA_IN != '0)},
                      {6'b0, 1'b1, 1'b1, cur_bc, cur_id, 5'b0, 1'b0, 1'b0});
            else
                check("idle_state",
                      {23'b0, bus.CMD_READY, bus.BUSY, bus.PL_ENA, bus.PL_INIT, bus.PL_WEN,
                       bus.PL_REN, bus.DONE, bus.PL_ADDR != 32'h0, bus.PL_DATA_IN != '0},
                      {23'b0, 9'b1_0000_0000});
        end
        if (bus.PL_WEN || bus.PL_REN)
            strobes.push_back('{cyc, bus.PL_ADDR[AW-1:0], bus.PL_DATA_IN, bus.PL_WEN});
        if (bus.PL_WEN)
            ram[bus.PL_ADDR[AW-1:0]] = bus.PL_DATA_IN;
        if (bus.PL_REN)
            rd_next = (corrupt && bus.PL_ADDR[AW-1:0] == corrupt_addr) ? '0 : ram[bus.PL_ADDR[AW-1:0]];
    end

    task automatic run_cmd(input bit wr, input bit bc, input logic [IW-1:0] id,
                           input logic [AW-1:0] base, input int len, input int vmode,
                           input bit cor, input int cidx);
        int            acc, last, done_c, i, guard, ns;
        bit            got_done, exp_mm, first, vtog;
        logic [AW-1:0] a, exp_err;
        logic [DW-1:0] ret;

        strobes.delete();
        acc_cyc.delete();
        exp_mm  = 1'b0;
        exp_err = '0;
        corrupt_addr = base + AW'(cidx);
        if (!wr) begin
            wq.delete();
            for (int k = 0; k < len; k++) begin
                a = base + AW'(k);
                wq.push_back(ref_mem[a]);
                ret = (cor && k == cidx) ? '0 : ref_mem[a];
                if (ret != wq[k] && !exp_mm) begin
                    exp_mm  = 1'b1;
                    exp_err = a;
                end
            end
        end else begin
            for (int k = 0; k < len; k++) ref_mem[base + AW'(k)] = wq[k];
        end
        cur_bc = bc;
        cur_id = id;

        @(posedge CLK); #1;
        bus.CMD_VALID  = 1'b1;
        bus.CMD_WRITE  = wr;
        bus.CMD_BCAST  = bc;
        bus.CMD_RAM_ID = id;
        bus.CMD_BASE   = base;
        bus.CMD_LEN    = (AW+1)'(len);
        corrupt        = cor;
        @(negedge CLK);
        check("cmd_rdy", bus.CMD_READY, 1);
        acc = cyc;
        @(posedge CLK); #1;
        bus.CMD_VALID = 1'b0;
        active = 1'b1;

        first = 1'b1;
        vtog  = 1'b1;
        i     = 0;
        guard = 0;
        while (i < len && guard < 20000) begin
            bus.DIN_VALID = (vmode == 0) ? 1'b1 : (vmode == 1) ? vtog : ($urandom_range(0, 99) >= 40);
            bus.DIN_DATA  = wq[i];
            vtog = !vtog;
            @(negedge CLK);
            if (first) begin check("mm_clr", bus.MISMATCH, 0); first = 1'b0; end
            if (bus.DIN_VALID && bus.DIN_READY) begin
                acc_cyc.push_back(cyc);
                i++;
            end
            guard++;
            @(posedge CLK); #1;
        end
        bus.DIN_VALID = 1'b0;
        bus.DIN_DATA  = '0;
        if (i < len) check("din_timeout", i, len);

        last     = (len == 0 || acc_cyc.size() == 0) ? acc : acc_cyc[acc_cyc.size()-1];
        got_done = 1'b0;
        done_c   = 0;
        for (int k = 0; k < 8 && !got_done; k++) begin
            @(negedge CLK);
            if (first) begin check("mm_clr", bus.MISMATCH, 0); first = 1'b0; end
            if (bus.DONE) begin
                got_done = 1'b1;
                done_c   = cyc;
            end else begin
                @(posedge CLK); #1;
            end
        end
        check("done_seen", got_done, 1);
        if (got_done)
            check("done_cyc", done_c, (len == 0) ? acc + 1 : last + (wr ? 2 : 3));
        check("mismatch", bus.MISMATCH, exp_mm);
        if (exp_mm) check("err_addr", bus.ERR_ADDR, exp_err);

        check("n_strobe", strobes.size(), len);
        ns = (strobes.size() < acc_cyc.size()) ? strobes.size() : acc_cyc.size();
        for (int j = 0; j < ns; j++) begin
            a = base + AW'(j);
            check("s_cyc",  strobes[j].cyc, acc_cyc[j] + 1);
            check("s_addr", strobes[j].a, a);
            check("s_dir",  strobes[j].w, wr);
            check("s_data", strobes[j].d, wr ? wq[j] : '0);
        end

        @(posedge CLK); #1;
        active  = 1'b0;
        corrupt = 1'b0;
        @(negedge CLK);
        check("done_pulse", bus.DONE, 0);
    endtask

    task automatic fill_random(input int len);
        wq.delete();
        for (int k = 0; k < len; k++) wq.push_back(DW'($urandom));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit wr, cor;
        int len;
        for (int k = 0; k < DEPTH; k++) begin
            ram[k]     = '0;
            ref_mem[k] = '0;
        end
        bus.CMD_VALID   = 1'b0;
        bus.CMD_WRITE   = 1'b0;
        bus.CMD_BCAST   = 1'b0;
        bus.CMD_RAM_ID  = '0;
        bus.CMD_BASE    = '0;
        bus.CMD_LEN     = '0;
        bus.DIN_VALID   = 1'b0;
        bus.DIN_DATA    = '0;
        bus.PL_DATA_OUT = '0;

        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_flags", {bus.CMD_READY, bus.BUSY, bus.DONE, bus.MISMATCH, bus.PL_INIT,
                            bus.PL_ENA, bus.PL_WEN, bus.PL_REN, bus.DIN_READY}, 9'b1_0000_0000);
        check("rst_addr", bus.PL_ADDR, 0);
        check("rst_din",  bus.PL_DATA_IN, 0);
        check("rst_err",  bus.ERR_ADDR, 0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // reset asserted mid-load aborts at once (data 0 keeps the BRAM model at its reset contents)
        @(posedge CLK); #1;
        bus.CMD_VALID = 1'b1; bus.CMD_WRITE = 1'b1; bus.CMD_BCAST = 1'b0;
        bus.CMD_RAM_ID = 16'h0005; bus.CMD_BASE = 11'h500; bus.CMD_LEN = 12'd8;
        @(posedge CLK); #1;
        bus.CMD_VALID = 1'b0;
        bus.DIN_VALID = 1'b1;
        bus.DIN_DATA  = '0;
        @(posedge CLK); #3;
        check("abort_pre_ena", bus.PL_ENA, 1);
        RST_N = 1'b0;
        #1;
        check("abort_ena",  bus.PL_ENA, 0);
        check("abort_busy", bus.BUSY, 0);
        check("abort_rdy",  bus.CMD_READY, 1);
        bus.DIN_VALID = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("abort_no_done", bus.DONE, 0);
        end
        @(posedge CLK); #1;
        RST_N  = 1'b1;
        mon_en = 1'b1;

        // back-to-back load
        wq = '{18'h3FFFF, 18'h00001, 18'h15555, 18'h2AAAA};
        run_cmd(1'b1, 1'b0, 16'h0003, 11'h010, 4, 0, 1'b0, 0);
        // same load with alternating DIN_VALID
        wq = '{18'h3FFFF, 18'h00001, 18'h15555, 18'h2AAAA};
        run_cmd(1'b1, 1'b0, 16'h0003, 11'h010, 4, 1, 1'b0, 0);
        // address wrap
        fill_random(3);
        run_cmd(1'b1, 1'b0, 16'h0007, 11'h7FF, 3, 0, 1'b0, 0);
        // verify with word 2 corrupted by the BRAM model
        run_cmd(1'b0, 1'b0, 16'h0003, 11'h010, 4, 0, 1'b1, 2);
        // zero-length command, also clears the sticky mismatch
        wq.delete();
        run_cmd(1'b1, 1'b0, 16'h0009, 11'h100, 0, 0, 1'b0, 0);
        // whole-RAM broadcast load
        fill_random(DEPTH);
        run_cmd(1'b1, 1'b1, 16'hABCD, 11'h123, DEPTH, 0, 1'b0, 0);

        // randomized mix of loads and verifies
        for (int n = 0; n < 24; n++) begin
            wr  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            cor = !wr && ($urandom_range(0, 1) == 1) && len > 0;
            if (wr) fill_random(len);
            run_cmd(wr, 1'($urandom_range(0, 1)), IW'($urandom), AW'($urandom), len,
                    $urandom_range(0, 2), cor, (len > 0) ? $urandom_range(0, len - 1) : 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
